// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, default-width
// access descriptor and a small state-classification helper.
package mem_port_arbiter_pkg;

   localparam int unsigned ARB_ADDR_W = 32;
   localparam int unsigned ARB_DATA_W = 32;
   localparam int unsigned ARB_BE_W   = ARB_DATA_W / 8;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY_IF = 2'd1,
      ARB_BUSY_DM = 2'd2
   } arb_state_t;

   typedef logic [ARB_BE_W-1:0] mem_be_t;

   // Default-width access descriptor as seen by the pipeline stages.
   typedef struct packed {
      logic                  we;
      mem_be_t               be;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
   } mem_req_t;

   // True while an access is outstanding on the memory bus.
   function automatic logic arb_is_busy(input arb_state_t s);
      logic busy;
      case (s)
         ARB_BUSY_IF: busy = 1'b1;
         ARB_BUSY_DM: busy = 1'b1;
         default:     busy = 1'b0;
      endcase
      return busy;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Saturating BUSY-cycle counter; flags when an access has waited TIMEOUT
// cycles without the memory completing it. TIMEOUT must be at least 1.
module arb_timeout_ctr #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise step while enabled and not yet expired.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (enable_i && !expired_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory bus arbiter between instruction fetch (IF) and the
// load/store unit (DM). DM has fixed priority; accesses are sequenced through
// a variable-latency ready handshake and aborted after TIMEOUT idle BUSY cycles.
// Note: rst_n is active-high despite its name.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [DATA_W/8-1:0] dm_be,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   output logic                dm_gnt,
   output logic                dm_rvalid,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                if_stall,
   output logic                dm_stall,
   output logic                bus_err
);

   localparam int unsigned BE_W = DATA_W / 8;

   // Parameter-width access fields held on the bus for the whole access.
   typedef struct packed {
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } acc_t;

   arb_state_t state_q, state_d;
   acc_t       acc_q, acc_d;
   logic       mem_req_q, mem_req_d;

   logic busy_s;
   logic arb_en_s;
   logic abort_s;
   logic expired_s;
   logic if_gnt_s, dm_gnt_s;
   logic cnt_clear_s, cnt_enable_s;

   assign busy_s = arb_is_busy(state_q);

   // Arbitration window, abort detection and next-state / next-access selection.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      arb_en_s  = (state_q == ARB_IDLE) || (busy_s && mem_ready);
      abort_s   = busy_s && !mem_ready && expired_s;
      dm_gnt_s  = !rst_n && arb_en_s && dm_req;
      if_gnt_s  = !rst_n && arb_en_s && if_req && !dm_req;
      if (dm_gnt_s) begin
         state_d = ARB_BUSY_DM;
         acc_d   = '{we: dm_we, be: dm_be, addr: dm_addr, wdata: dm_wdata};
      end else if (if_gnt_s) begin
         state_d = ARB_BUSY_IF;
         acc_d   = '{we: 1'b0, be: {BE_W{1'b1}}, addr: if_addr, wdata: {DATA_W{1'b0}}};
      end else if (abort_s || arb_en_s) begin
         state_d = ARB_IDLE;
      end else begin
         state_d = state_q;
      end
      mem_req_d = (state_d != ARB_IDLE);
   end

   // Arbiter FSM with the registered memory-bus request and access fields.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q   <= ARB_IDLE;
         acc_q     <= '0;
         mem_req_q <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_DM: begin
               state_q   <= state_d;
               acc_q     <= acc_d;
               mem_req_q <= mem_req_d;
            end
            default: begin
               state_q   <= ARB_IDLE;
               acc_q     <= acc_q;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   // Counter restarts whenever a new access is granted or the bus is idle.
   assign cnt_clear_s  = if_gnt_s || dm_gnt_s || !busy_s;
   assign cnt_enable_s = busy_s && !mem_ready;

   arb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk_i     (clk),
      .rst_i     (rst_n),
      .clear_i   (cnt_clear_s),
      .enable_i  (cnt_enable_s),
      .expired_o (expired_s)
   );

   // Completion/abort responses and stall generation toward the pipeline.
   always_comb begin
      if_gnt    = if_gnt_s;
      dm_gnt    = dm_gnt_s;
      if_rvalid = (state_q == ARB_BUSY_IF) && (mem_ready || abort_s);
      dm_rvalid = (state_q == ARB_BUSY_DM) && (mem_ready || abort_s);
      if_rdata  = {DATA_W{1'b0}};
      dm_rdata  = {DATA_W{1'b0}};
      if ((state_q == ARB_BUSY_IF) && mem_ready) begin
         if_rdata = mem_rdata;
      end else begin
         if_rdata = {DATA_W{1'b0}};
      end
      if ((state_q == ARB_BUSY_DM) && mem_ready && !acc_q.we) begin
         dm_rdata = mem_rdata;
      end else begin
         dm_rdata = {DATA_W{1'b0}};
      end
      bus_err  = abort_s;
      if_stall = !rst_n && ((if_req && !if_gnt_s) ||
                            ((state_q == ARB_BUSY_IF) && !if_rvalid));
      dm_stall = !rst_n && ((dm_req && !dm_gnt_s) ||
                            ((state_q == ARB_BUSY_DM) && !dm_rvalid));
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = acc_q.we;
   assign mem_be    = acc_q.be;
   assign mem_addr  = acc_q.addr;
   assign mem_wdata = acc_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt, if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req, dm_we;
   logic [3:0]        dm_be;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt, dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;
   logic              mem_req, mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              if_stall, dm_stall, bus_err;

   int n_checks = 0;
   int n_errors = 0;

   mem_port_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_be     (dm_be),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_gnt    (dm_gnt),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .if_stall  (if_stall),
      .dm_stall  (dm_stall),
      .bus_err   (bus_err)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1;  if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = '0; dm_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;

      // Reset state
      smp;
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_if_gnt", 64'(if_gnt), 64'd0);
      chk("rst_bus_err", 64'(bus_err), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      rst_n = 1'b0;

      // Fetch only, memory ready 2 cycles after mem_req rises
      cyc; if_req = 1'b1; if_addr = 32'h100;
      smp;
      chk("f_gnt_c0", 64'(if_gnt), 64'd1);
      chk("f_memreq_c0", 64'(mem_req), 64'd0);
      chk("f_stall_c0", 64'(if_stall), 64'd0);
      cyc; if_req = 1'b0;
      smp;
      chk("f_memreq_c1", 64'(mem_req), 64'd1);
      chk("f_addr_c1", 64'(mem_addr), 64'h100);
      chk("f_we_c1", 64'(mem_we), 64'd0);
      chk("f_stall_c1", 64'(if_stall), 64'd1);
      chk("f_rvalid_c1", 64'(if_rvalid), 64'd0);
      cyc;
      smp;
      chk("f_memreq_c2", 64'(mem_req), 64'd1);
      chk("f_rvalid_c2", 64'(if_rvalid), 64'd0);
      cyc; mem_ready = 1'b1; mem_rdata = 32'h00500093;
      smp;
      chk("f_memreq_c3", 64'(mem_req), 64'd1);
      chk("f_rvalid_c3", 64'(if_rvalid), 64'd1);
      chk("f_rdata_c3", 64'(if_rdata), 64'h00500093);
      chk("f_stall_c3", 64'(if_stall), 64'd0);
      cyc; mem_ready = 1'b0;
      smp;
      chk("f_memreq_c4", 64'(mem_req), 64'd0);
      chk("f_rvalid_c4", 64'(if_rvalid), 64'd0);

      // Simultaneous requests, zero-wait memory
      cyc; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; if_req = 1'b1; if_addr = 32'h104;
      smp;
      chk("s_dmgnt_c0", 64'(dm_gnt), 64'd1);
      chk("s_ifgnt_c0", 64'(if_gnt), 64'd0);
      chk("s_ifstall_c0", 64'(if_stall), 64'd1);
      chk("s_dmstall_c0", 64'(dm_stall), 64'd0);
      cyc; dm_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h11112222;
      smp;
      chk("s_memreq_c1", 64'(mem_req), 64'd1);
      chk("s_addr_c1", 64'(mem_addr), 64'h2000);
      chk("s_dmrv_c1", 64'(dm_rvalid), 64'd1);
      chk("s_dmrd_c1", 64'(dm_rdata), 64'h11112222);
      chk("s_ifgnt_c1", 64'(if_gnt), 64'd1);
      chk("s_ifstall_c1", 64'(if_stall), 64'd0);
      cyc; if_req = 1'b0; mem_rdata = 32'h33334444;
      smp;
      chk("s_memreq_c2", 64'(mem_req), 64'd1);
      chk("s_addr_c2", 64'(mem_addr), 64'h104);
      chk("s_ifrv_c2", 64'(if_rvalid), 64'd1);
      chk("s_ifrd_c2", 64'(if_rdata), 64'h33334444);
      chk("s_dmrv_c2", 64'(dm_rvalid), 64'd0);
      cyc; mem_ready = 1'b0;
      smp;
      chk("s_memreq_c3", 64'(mem_req), 64'd0);

      // Store acknowledge
      cyc; dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h3000; dm_wdata = 32'hDEADBEEF;
      smp;
      chk("st_gnt", 64'(dm_gnt), 64'd1);
      cyc; dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_wdata = '0;
      mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
      smp;
      chk("st_memwe", 64'(mem_we), 64'd1);
      chk("st_membe", 64'(mem_be), 64'h3);
      chk("st_wdata", 64'(mem_wdata), 64'hDEADBEEF);
      chk("st_rvalid", 64'(dm_rvalid), 64'd1);
      chk("st_rdata", 64'(dm_rdata), 64'd0);

      // Stale mem_ready in IDLE
      cyc;
      smp;
      chk("idle_memreq", 64'(mem_req), 64'd0);
      chk("idle_ifrv", 64'(if_rvalid), 64'd0);
      chk("idle_dmrv", 64'(dm_rvalid), 64'd0);

      // Timeout: TIMEOUT = 4, mem_ready held low
      cyc; mem_ready = 1'b0; mem_rdata = 32'hA5A5A5A5; if_req = 1'b1; if_addr = 32'h200;
      smp;
      chk("to_gnt", 64'(if_gnt), 64'd1);
      cyc; if_req = 1'b0;
      smp;
      chk("to_memreq_c1", 64'(mem_req), 64'd1);
      chk("to_err_c1", 64'(bus_err), 64'd0);
      for (int k = 2; k <= 4; k++) begin
         cyc;
         smp;
         chk($sformatf("to_err_c%0d", k), 64'(bus_err), 64'd0);
         chk($sformatf("to_rv_c%0d", k), 64'(if_rvalid), 64'd0);
      end
      cyc; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000;
      smp;
      chk("to_err_c5", 64'(bus_err), 64'd1);
      chk("to_rv_c5", 64'(if_rvalid), 64'd1);
      chk("to_rd_c5", 64'(if_rdata), 64'd0);
      chk("to_noarb_c5", 64'(dm_gnt), 64'd0);
      chk("to_dmstall_c5", 64'(dm_stall), 64'd1);
      cyc;
      smp;
      chk("to_memreq_c6", 64'(mem_req), 64'd0);
      chk("to_err_c6", 64'(bus_err), 64'd0);
      chk("to_dmgnt_c6", 64'(dm_gnt), 64'd1);
      cyc; dm_req = 1'b0;
      smp;
      chk("busydm_memreq", 64'(mem_req), 64'd1);
      chk("busydm_addr", 64'(mem_addr), 64'h4000);
      chk("busydm_stall", 64'(dm_stall), 64'd1);

      // Reset mid-access (asynchronous)
      #2; rst_n = 1'b1; dm_req = 1'b1; if_req = 1'b1; mem_ready = 1'b1;
      #1;
      chk("ra_memreq", 64'(mem_req), 64'd0);
      chk("ra_addr", 64'(mem_addr), 64'd0);
      chk("ra_dmgnt", 64'(dm_gnt), 64'd0);
      chk("ra_ifgnt", 64'(if_gnt), 64'd0);
      chk("ra_dmrv", 64'(dm_rvalid), 64'd0);
      chk("ra_stalls", 64'({if_stall, dm_stall}), 64'd0);
      chk("ra_err", 64'(bus_err), 64'd0);
      cyc; rst_n = 1'b0; dm_req = 1'b0; if_req = 1'b0;
      smp;
      chk("ra_stray_dmrv", 64'(dm_rvalid), 64'd0);
      chk("ra_stray_ifrv", 64'(if_rvalid), 64'd0);
      chk("ra_stray_memreq", 64'(mem_req), 64'd0);
      cyc; mem_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
